// File: rtl/mon_pkg.sv
// Shared types and default widths for the register-file checkpoint monitor.
// Optional feature macro (see top): MON_HALT_ON_FAIL_EN.
package mon_pkg;

    localparam int MON_DATA_W     = 32;
    localparam int MON_REG_AW     = 5;
    localparam int MON_NUM_CHECKS = 16;
    localparam int MON_CYC_W      = 32;
    localparam int MON_MAX_CYCLES = 1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mon_state_t;

    // Default checkpoint layout; the table stores entries packed in this field order.
    typedef struct packed {
        logic [MON_CYC_W-1:0]  cycle;
        logic [MON_REG_AW-1:0] reg_addr;
        logic [MON_DATA_W-1:0] value;
    } mon_entry_t;

endpackage

// File: rtl/monitor_check_table.sv
// Checkpoint table: one write port, a full-entry read at ptr and a cycle-only
// read at ptr+1, both combinational so the compare happens in the same clock.
module monitor_check_table
    import mon_pkg::*;
#(
    parameter int DEPTH = MON_NUM_CHECKS,
    parameter int IDX_W = $clog2(MON_NUM_CHECKS),
    parameter int CYC_W = MON_CYC_W,
    parameter int ENT_W = MON_CYC_W + MON_REG_AW + MON_DATA_W
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [ENT_W-1:0] wr_entry,
    input  logic [IDX_W-1:0] rd_idx_a,
    output logic [ENT_W-1:0] rd_entry_a,
    input  logic [IDX_W-1:0] rd_idx_b,
    output logic [CYC_W-1:0] rd_cycle_b
);

    logic [ENT_W-1:0] mem_q [DEPTH];

    // Contents deliberately survive reset so a run can be restarted without reloading.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_entry;
        end
    end

    assign rd_entry_a = mem_q[rd_idx_a];
    assign rd_cycle_b = mem_q[rd_idx_b][ENT_W-1 -: CYC_W];

endmodule

// File: rtl/regfile_checkpoint_monitor.sv
// Snoops the register file at listed cycles and compares against expected values.
// Define MON_HALT_ON_FAIL_EN to stop the run at the first failing entry.
module regfile_checkpoint_monitor
    import mon_pkg::*;
#(
    parameter int DATA_W     = MON_DATA_W,
    parameter int REG_AW     = MON_REG_AW,
    parameter int NUM_CHECKS = MON_NUM_CHECKS,
    parameter int CYC_W      = MON_CYC_W,
    parameter int MAX_CYCLES = MON_MAX_CYCLES,
    parameter int IDX_W      = $clog2(NUM_CHECKS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [CYC_W-1:0]  cfg_cycle,
    input  logic [REG_AW-1:0] cfg_reg,
    input  logic [DATA_W-1:0] cfg_value,
    input  logic [IDX_W:0]    cfg_num,
    input  logic              start,
    output logic [REG_AW-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              cpu_stall,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [IDX_W:0]    fail_cnt,
    output logic [IDX_W-1:0]  first_fail_idx,
    output logic [CYC_W-1:0]  cyc_cnt
);

    localparam int ENT_W = CYC_W + REG_AW + DATA_W;

    typedef struct packed {
        logic [CYC_W-1:0]  cycle;
        logic [REG_AW-1:0] reg_addr;
        logic [DATA_W-1:0] value;
    } entry_t;

    mon_state_t        state_q, state_d;
    logic [IDX_W:0]    num_q, num_d;
    logic [IDX_W:0]    ptr_q, ptr_d;
    logic [IDX_W:0]    fail_cnt_q, fail_cnt_d;
    logic [IDX_W-1:0]  first_fail_q, first_fail_d;
    logic              timeout_q, timeout_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;

    entry_t            ent;
    logic [CYC_W-1:0]  nx_cycle;
    logic [IDX_W:0]    ptr_nx;
    logic              consume;
    logic              fail_now;
    logic              stall;

    assign ptr_nx = ptr_q + 1'b1;

    monitor_check_table #(
        .DEPTH (NUM_CHECKS),
        .IDX_W (IDX_W),
        .CYC_W (CYC_W),
        .ENT_W (ENT_W)
    ) u_table (
        .clk        (clk),
        .wr_en      (cfg_we && (state_q != RUN)),
        .wr_idx     (cfg_idx),
        .wr_entry   ({cfg_cycle, cfg_reg, cfg_value}),
        .rd_idx_a   (ptr_q[IDX_W-1:0]),
        .rd_entry_a (ent),
        .rd_idx_b   (ptr_nx[IDX_W-1:0]),
        .rd_cycle_b (nx_cycle)
    );

    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        ptr_d        = ptr_q;
        fail_cnt_d   = fail_cnt_q;
        first_fail_d = first_fail_q;
        timeout_d    = timeout_q;
        cyc_d        = cyc_q;
        rf_addr      = '0;
        consume      = 1'b0;
        fail_now     = 1'b0;
        stall        = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = RUN;
                    num_d        = (cfg_num > (IDX_W+1)'(NUM_CHECKS)) ? (IDX_W+1)'(NUM_CHECKS) : cfg_num;
                    ptr_d        = '0;
                    cyc_d        = CYC_W'(1);
                    fail_cnt_d   = '0;
                    first_fail_d = '0;
                    timeout_d    = 1'b0;
                end
            end
            RUN: begin
                if (ptr_q >= num_q) begin
                    state_d = DONE;
                end else begin
                    if (ent.cycle == cyc_q) begin
                        rf_addr  = ent.reg_addr;
                        consume  = 1'b1;
                        fail_now = (rf_data != ent.value);
                    end else if (ent.cycle < cyc_q) begin
                        // Entry already in the past: missed or table not sorted.
                        consume  = 1'b1;
                        fail_now = 1'b1;
                    end
                    if (consume) begin
                        ptr_d = ptr_nx;
                    end
                    if (fail_now) begin
                        fail_cnt_d = fail_cnt_q + 1'b1;
                        if (fail_cnt_q == '0) begin
                            first_fail_d = ptr_q[IDX_W-1:0];
                        end
                    end
                    // Freeze the core so the next same-cycle entry sees the same register state.
                    stall = consume && (ptr_nx < num_q) && (nx_cycle == cyc_q);
`ifdef MON_HALT_ON_FAIL_EN
                    if (fail_now) begin
                        stall   = 1'b0;
                        state_d = DONE;
                    end
`endif
                    if (!stall && (cyc_q != '1)) begin
                        cyc_d = cyc_q + 1'b1;
                    end
                    if ((state_d == RUN) && !stall && (cyc_q >= CYC_W'(MAX_CYCLES)) && (ptr_d < num_q)) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                        cyc_d     = cyc_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cpu_stall = stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            num_q        <= '0;
            ptr_q        <= '0;
            fail_cnt_q   <= '0;
            first_fail_q <= '0;
            timeout_q    <= 1'b0;
            cyc_q        <= '0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            ptr_q        <= ptr_d;
            fail_cnt_q   <= fail_cnt_d;
            first_fail_q <= first_fail_d;
            timeout_q    <= timeout_d;
            cyc_q        <= cyc_d;
        end
    end

    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign pass           = done && (fail_cnt_q == '0) && !timeout_q;
    assign timeout        = timeout_q;
    assign fail_cnt       = fail_cnt_q;
    assign first_fail_idx = first_fail_q;
    assign cyc_cnt        = cyc_q;

endmodule

// File: tb/tb_regfile_checkpoint_monitor.sv
// Directed bench for regfile_checkpoint_monitor: a table of run scenarios plus
// hand sequences for reset, empty run, mid-run reset, dropped writes and clamping.
module tb_regfile_checkpoint_monitor;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int IW = 4;
    localparam int CW = 32;
`ifdef MON_HALT_ON_FAIL_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [CW-1:0] cfg_cycle = '0;
    logic [AW-1:0] cfg_reg = '0;
    logic [DW-1:0] cfg_value = '0;
    logic [IW:0]   cfg_num = '0;
    logic          start = 1'b0;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          cpu_stall, busy, done, pass, timeout;
    logic [IW:0]   fail_cnt;
    logic [IW-1:0] first_fail_idx;
    logic [CW-1:0] cyc_cnt;

    logic [DW-1:0] rf_mem [32];
    assign rf_data = rf_mem[rf_addr];

    always #5 clk = ~clk;

    regfile_checkpoint_monitor #(
        .DATA_W(DW), .REG_AW(AW), .NUM_CHECKS(16), .CYC_W(CW), .MAX_CYCLES(1000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_cycle(cfg_cycle), .cfg_reg(cfg_reg), .cfg_value(cfg_value),
        .cfg_num(cfg_num), .start(start), .rf_addr(rf_addr), .rf_data(rf_data),
        .cpu_stall(cpu_stall), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .fail_cnt(fail_cnt), .first_fail_idx(first_fail_idx),
        .cyc_cnt(cyc_cnt)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic write_entry(input int idx, input int c, input int r, input int v);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_idx   = IW'(idx);
        cfg_cycle = CW'(c);
        cfg_reg   = AW'(r);
        cfg_value = DW'(v);
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_start(input int num);
        @(negedge clk);
        cfg_num = (IW+1)'(num);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Called at the negedge right after the start edge; counts stall cycles until done.
    task automatic run_to_done(input string nm, output int stalls);
        bit seen;
        stalls = 0;
        seen = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (cpu_stall) stalls++;
            @(negedge clk);
        end
        chk({nm, "_done_reached"}, seen, 1);
    endtask

    typedef struct {
        int n;
        int c0, r0, v0, c1, r1, v1, c2, r2, v2;
        int num;
        int exp_fail, exp_ffi, exp_pass, exp_to, exp_stall, exp_cyc;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int stalls;
        string nm;

        for (int i = 0; i < 32; i++) rf_mem[i] = DW'(i * 100);
        rf_mem[19] = 30;
        rf_mem[20] = 20;
        rf_mem[21] = 6;

        //             n  c0   r0 v0   c1 r1 v1   c2 r2 v2  num fail                ffi pass to stall              cyc
        vecs[0] = '{3, 15,  19, 30,  15, 20, 20, 15, 21, 6, 3, 0,                  0,  1,   0, 2,                 16};
        vecs[1] = '{3, 15,  19, 30,  15, 20, 21, 15, 21, 6, 3, 1,                  1,  0,   0, HALT ? 1 : 2,      16};
        vecs[2] = '{2, 10,  5,  500, 5,  6,  600, 0, 0,  0, 2, 1,                  1,  0,   0, 0,                 12};
        vecs[3] = '{2, 8,   3,  1,   12, 4,  2,   0, 0,  0, 2, HALT ? 1 : 2,       0,  0,   0, 0,                 HALT ? 9 : 13};
        vecs[4] = '{3, 3,   1,  100, 6,  2,  7,   9, 3,  8, 3, HALT ? 1 : 2,       1,  0,   0, 0,                 HALT ? 7 : 10};
        vecs[5] = '{2, 4,   1,  100, 5,  2,  9,   0, 0,  0, 1, 0,                  0,  1,   0, 0,                 5};
        vecs[6] = '{1, 2000,19, 30,  0,  0,  0,   0, 0,  0, 1, 0,                  0,  0,   1, 0,                 1000};

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_rf_addr", rf_addr, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        chk("rst_cyc_cnt", cyc_cnt, 0);
        $display("txn reset: busy=%0d done=%0d cyc=%0d", busy, done, cyc_cnt);

        // Empty run: done and pass one clock after start, no stall
        pulse_start(0);
        chk("empty_busy", busy, 1);
        chk("empty_stall0", cpu_stall, 0);
        @(negedge clk);
        chk("empty_done", done, 1);
        chk("empty_pass", pass, 1);
        chk("empty_stall1", cpu_stall, 0);
        $display("txn empty: done=%0d pass=%0d", done, pass);

        for (int v = 0; v < 7; v++) begin
            nm = $sformatf("vec%0d", v);
            if (vecs[v].n > 0) write_entry(0, vecs[v].c0, vecs[v].r0, vecs[v].v0);
            if (vecs[v].n > 1) write_entry(1, vecs[v].c1, vecs[v].r1, vecs[v].v1);
            if (vecs[v].n > 2) write_entry(2, vecs[v].c2, vecs[v].r2, vecs[v].v2);
            pulse_start(vecs[v].num);
            run_to_done(nm, stalls);
            chk({nm, "_fail_cnt"}, fail_cnt, vecs[v].exp_fail);
            if (vecs[v].exp_fail != 0) chk({nm, "_first_fail"}, first_fail_idx, vecs[v].exp_ffi);
            chk({nm, "_pass"}, pass, vecs[v].exp_pass);
            chk({nm, "_timeout"}, timeout, vecs[v].exp_to);
            chk({nm, "_stalls"}, stalls, vecs[v].exp_stall);
            chk({nm, "_cyc_cnt"}, cyc_cnt, vecs[v].exp_cyc);
            chk({nm, "_done_stall"}, cpu_stall, 0);
            chk({nm, "_done_rf_addr"}, rf_addr, 0);
            $display("txn %s: fail_cnt=%0d ffi=%0d pass=%0d timeout=%0d stalls=%0d cyc=%0d",
                     nm, fail_cnt, first_fail_idx, pass, timeout, stalls, cyc_cnt);
        end

        // Reset during the cycle-15 stall, with a cfg write attempted mid-run
        write_entry(0, 15, 19, 30);
        write_entry(1, 15, 20, 20);
        write_entry(2, 15, 21, 6);
        pulse_start(3);
        write_entry(1, 15, 20, 99);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (cpu_stall) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            chk("midrst_stall_seen", seen, 1);
            chk("midrst_rf_addr_at_stall", rf_addr, 19);
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_stall", cpu_stall, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_cyc_cnt", cyc_cnt, 0);
        chk("midrst_rf_addr", rf_addr, 0);
        $display("txn midrun_reset: stall=%0d busy=%0d cyc=%0d", cpu_stall, busy, cyc_cnt);
        rst_n = 1'b1;
        pulse_start(3);
        run_to_done("rerun", stalls);
        chk("rerun_fail_cnt", fail_cnt, 0);
        chk("rerun_pass", pass, 1);
        chk("rerun_stalls", stalls, 2);
        $display("txn rerun_after_reset: fail_cnt=%0d pass=%0d stalls=%0d", fail_cnt, pass, stalls);

        // Full table with an oversize cfg_num: must clamp to 16 entries
        for (int i = 0; i < 16; i++) write_entry(i, i + 2, i + 1, (i + 1) * 100);
        pulse_start(31);
        run_to_done("clamp", stalls);
        chk("clamp_fail_cnt", fail_cnt, 0);
        chk("clamp_pass", pass, 1);
        chk("clamp_cyc_cnt", cyc_cnt, 18);
        $display("txn clamp: fail_cnt=%0d pass=%0d cyc=%0d", fail_cnt, pass, cyc_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
